// File: rtl/apb_pkg.sv
// Shared types and constants for the APB requester: FSM states, PPROT bit positions,
// and the command/response records sized for the widest supported bus.
package apb_pkg;

    localparam int unsigned APB_MAX_ADDR_W = 32;
    localparam int unsigned APB_MAX_DATA_W = 32;
    localparam int unsigned APB_MAX_STRB_W = APB_MAX_DATA_W / 8;

    localparam int unsigned PPROT_PRIV   = 0;
    localparam int unsigned PPROT_NONSEC = 1;
    localparam int unsigned PPROT_INSTR  = 2;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } apb_state_e;

    typedef struct packed {
        logic                      write;
        logic [APB_MAX_ADDR_W-1:0] addr;
        logic [APB_MAX_DATA_W-1:0] wdata;
        logic [APB_MAX_STRB_W-1:0] strb;
        logic [2:0]                prot;
    } apb_cmd_t;

    typedef struct packed {
        logic [APB_MAX_DATA_W-1:0] rdata;
        logic                      err;
        logic                      timeout;
    } apb_rsp_t;

    function automatic logic apb_data_width_ok(input int unsigned width);
        return (width == 8) || (width == 16) || (width == 32);
    endfunction

endpackage

// File: rtl/apb_access_timer.sv
// ACCESS-phase wait-state counter; used by apb_requester only when APB_TIMEOUT_EN is defined.
// Asserts expired on the wait cycle whose count reaches TIMEOUT_CYCLES with PREADY still low.
module apb_access_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic busy,
    input  logic pready,
    output logic expired
);

    localparam logic [15:0] Limit = 16'(TIMEOUT_CYCLES);

    logic [15:0] count_q;
    logic [15:0] count_d;
    logic [15:0] count_inc;

    assign count_inc = count_q + 16'd1;
    assign expired   = busy && !pready && (count_inc == Limit);

    always_comb begin
        count_d = count_q;
        if (start) begin
            count_d = '0;
        end else if (busy && !pready) begin
            count_d = count_inc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/apb_requester.sv
// APB4 requester: one command in, one SETUP/ACCESS transfer out, one response back.
// Define APB_TIMEOUT_EN to abort ACCESS phases that wait longer than TIMEOUT_CYCLES.
module apb_requester
    import apb_pkg::*;
#(
    parameter int unsigned APB_PADDR_WIDTH = 32,
    parameter int unsigned APB_PDATA_WIDTH = 32,
    parameter int unsigned TIMEOUT_CYCLES  = 16
) (
    input  logic                         PCLK,
    input  logic                         PRESET,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic                         cmd_write,
    input  logic [APB_PADDR_WIDTH-1:0]   cmd_addr,
    input  logic [APB_PDATA_WIDTH-1:0]   cmd_wdata,
    input  logic [APB_PDATA_WIDTH/8-1:0] cmd_strb,
    input  logic [2:0]                   cmd_prot,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [APB_PDATA_WIDTH-1:0]   rsp_rdata,
    output logic                         rsp_err,
    output logic                         rsp_timeout,
    output logic [APB_PADDR_WIDTH-1:0]   PADDR,
    output logic [2:0]                   PPROT,
    output logic                         PSEL,
    output logic                         PENABLE,
    output logic                         PWRITE,
    output logic [APB_PDATA_WIDTH-1:0]   PWDATA,
    output logic [APB_PDATA_WIDTH/8-1:0] PSTRB,
    input  logic                         PREADY,
    input  logic [APB_PDATA_WIDTH-1:0]   PRDATA,
    input  logic                         PSLVERR
);

    localparam int unsigned StrbW = APB_PDATA_WIDTH / 8;

    if (!apb_data_width_ok(APB_PDATA_WIDTH)) begin : g_bad_data_width
        $error("apb_requester: APB_PDATA_WIDTH must be 8, 16 or 32");
    end
    if (APB_PADDR_WIDTH < 1 || APB_PADDR_WIDTH > APB_MAX_ADDR_W) begin : g_bad_addr_width
        $error("apb_requester: APB_PADDR_WIDTH out of range");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("apb_requester: TIMEOUT_CYCLES must be 1..65535");
    end

    apb_state_e state_q, state_d;
    apb_cmd_t   cmd_q, cmd_d;
    apb_rsp_t   rsp_q, rsp_d;
    logic       psel_q, psel_d;
    logic       penable_q, penable_d;
    logic       rsp_valid_q, rsp_valid_d;
    logic       expired;

`ifdef APB_TIMEOUT_EN
    apb_access_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (PCLK),
        .rst    (PRESET),
        .start  (state_q == SETUP),
        .busy   (state_q == ACCESS),
        .pready (PREADY),
        .expired(expired)
    );
`else
    assign expired = 1'b0;
`endif

    // Gated by PRESET so every output reads 0 while reset is held.
    assign cmd_ready = !PRESET && (state_q == IDLE) && (!rsp_valid_q || rsp_ready);

    assign PADDR       = cmd_q.addr[APB_PADDR_WIDTH-1:0];
    assign PPROT       = cmd_q.prot;
    assign PWRITE      = cmd_q.write;
    assign PWDATA      = cmd_q.wdata[APB_PDATA_WIDTH-1:0];
    assign PSTRB       = psel_q ? cmd_q.strb[StrbW-1:0] : '0;
    assign PSEL        = psel_q;
    assign PENABLE     = penable_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_q.rdata[APB_PDATA_WIDTH-1:0];
    assign rsp_err     = rsp_q.err;
    assign rsp_timeout = rsp_q.timeout;

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        rsp_d       = rsp_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        rsp_valid_d = rsp_valid_q;

        if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    // Read commands carry zero data and strobes onto the bus.
                    cmd_d.write = cmd_write;
                    cmd_d.addr  = APB_MAX_ADDR_W'(cmd_addr);
                    cmd_d.wdata = cmd_write ? APB_MAX_DATA_W'(cmd_wdata) : '0;
                    cmd_d.strb  = cmd_write ? APB_MAX_STRB_W'(cmd_strb) : '0;
                    cmd_d.prot  = cmd_prot;
                    psel_d      = 1'b1;
                    state_d     = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                state_d   = ACCESS;
            end
            ACCESS: begin
                if (PREADY) begin
                    rsp_d.rdata   = cmd_q.write ? '0 : APB_MAX_DATA_W'(PRDATA);
                    rsp_d.err     = PSLVERR;
                    rsp_d.timeout = 1'b0;
                    rsp_valid_d   = 1'b1;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    state_d       = IDLE;
                end else if (expired) begin
                    rsp_d.rdata   = '0;
                    rsp_d.err     = 1'b1;
                    rsp_d.timeout = 1'b1;
                    rsp_valid_d   = 1'b1;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    state_d       = IDLE;
                end
            end
            default: begin
                psel_d    = 1'b0;
                penable_d = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q     <= IDLE;
            cmd_q       <= '0;
            rsp_q       <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            rsp_q       <= rsp_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

endmodule

// File: doc/apb_requester.md
Name: apb_requester

Overview:
- APB4 requester (initiator) for the team's APB bus.
- Converts a valid/ready command stream (write/read, address, data, strobes, protection) into single APB transfers on the shared APB signal set, then returns read data and the error status on a valid/ready response stream.
- Sits between an internal master (DMA, CPU bridge, test sequencer) and APB completers.
- Handles one outstanding transfer at a time.

Parameters:
- APB_PADDR_WIDTH, 32, address width of PADDR and cmd_addr.
- APB_PDATA_WIDTH, 32, data width of PWDATA/PRDATA; must be 8, 16 or 32.
- TIMEOUT_CYCLES, 16, ACCESS-phase cycle limit used only when APB_TIMEOUT_EN is defined; range 1 to 65535.

Ports:
- PCLK  in  1  bus clock, all logic on the rising edge.
- PRESET  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid and cmd_ready are both high on an edge.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  APB_PADDR_WIDTH  transfer address.
- cmd_wdata  in  APB_PDATA_WIDTH  write data.
- cmd_strb  in  APB_PDATA_WIDTH/8  write byte strobes.
- cmd_prot  in  3  protection attributes.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  APB_PDATA_WIDTH  read data; 0 for writes.
- rsp_err  out  1  PSLVERR seen, or timeout occurred.
- rsp_timeout  out  1  transfer aborted by timeout.
- PADDR, PPROT, PSEL, PENABLE, PWRITE, PWDATA, PSTRB  out  per APB  requester-driven APB signals.
- PREADY, PRDATA, PSLVERR  in  per APB  completer-driven APB signals.

Behaviour:
- Clock and reset: one clock, PCLK. Reset PRESET is asynchronous and active-high.
- Reset values: every output is 0 and the state is IDLE.
- Reset mid-transfer: PSEL and PENABLE drop immediately. No response is produced and any pending rsp_valid is discarded.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - cmd_ready = !rsp_valid || rsp_ready.
  - On accept, register all cmd_* fields and go to SETUP.
- SETUP (exactly 1 cycle):
  - PSEL=1, PENABLE=0. PADDR, PPROT and PWRITE are driven from the registered command.
  - For writes, PWDATA=wdata and PSTRB=strb.
  - For reads, PSTRB=0 and PWDATA=0.
  - Always go to ACCESS.
- ACCESS:
  - PSEL=1, PENABLE=1. All address, control and data outputs are held stable, bit-identical to SETUP.
  - PREADY=1 on an edge completes the transfer:
    - capture PRDATA (reads only; writes return 0) and PSLVERR;
    - set rsp_valid=1 and rsp_timeout=0;
    - go to IDLE with PSEL=0 and PENABLE=0 on the next cycle.
  - PREADY=0: stay in ACCESS (wait state).
- Response handshake:
  - rsp_valid stays high, with rsp_* stable, until rsp_ready is sampled high.
  - rsp_valid clears on that edge unless a new response is being produced on the same edge. That cannot happen, because a transfer needs at least 2 cycles.
- Latency and throughput:
  - Command accepted on edge 0 → SETUP in cycle 1 → ACCESS in cycle 2 → rsp_valid in cycle 3 when there are zero wait states.
  - Back-to-back: with rsp_ready tied high, the next command is accepted in cycle 3 and its SETUP is in cycle 4. PSEL is low for 1 cycle between transfers.
- Backpressure: rsp_ready held low blocks cmd_ready. The APB bus stays idle (PSEL=0) while blocked.
- Outside SETUP/ACCESS, PADDR, PWRITE and PWDATA hold their last values. PSTRB is 0.
- A PSLVERR value sampled while PREADY=0 is ignored.

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on entry to ACCESS and increments each ACCESS cycle with PREADY=0.
  - When the count reaches TIMEOUT_CYCLES and PREADY is still 0, the transfer aborts. The FSM goes to IDLE (PSEL=0, PENABLE=0 next cycle).
  - The response is rsp_valid=1, rsp_err=1, rsp_timeout=1, rsp_rdata=0.
  - If PREADY=1 arrives on the limit cycle, normal completion wins.
- Undefined: no counter is built, rsp_timeout is tied to 0, and ACCESS waits indefinitely.

Decomposition:
- Package apb_pkg:
  - state enum apb_state_e {IDLE, SETUP, ACCESS};
  - PPROT bit-index constants (PRIV=0, NONSEC=1, INSTR=2);
  - a command struct typedef (write, addr, wdata, strb, prot);
  - a response struct typedef (rdata, err, timeout).
- Sub-module apb_access_timer: the timeout counter. It takes start, busy and PREADY inputs and produces an expired output, and is instantiated only under APB_TIMEOUT_EN.

Test Plan:
- Write with zero wait states: addr=0x0000_0010, wdata=0xDEAD_BEEF, strb=0xF → SETUP and ACCESS each last 1 cycle; PSTRB=0xF; rsp_valid in cycle 3 with rsp_err=0 and rsp_rdata=0.
- Read with 3 wait states (PREADY low for 3 ACCESS cycles, PRDATA=0x1234_5678) → PENABLE high for 4 cycles with PADDR stable; PSTRB=0; rsp_rdata=0x1234_5678.
- PSLVERR=1 with PREADY=1 on a write → rsp_err=1, rsp_timeout=0; the next command proceeds normally.
- Backpressure: rsp_ready=0 for 5 cycles after a response → cmd_ready=0 and PSEL=0 throughout; the response fields are unchanged; the command is accepted on the first edge with rsp_ready=1.
- Reset in ACCESS: assert PRESET mid-wait-state → PSEL, PENABLE and rsp_valid are 0 immediately (before the next edge); the FSM is in IDLE after release.
- APB_TIMEOUT_EN with TIMEOUT_CYCLES=4 and PREADY held 0 → abort after 4 ACCESS cycles; rsp_err=1, rsp_timeout=1, rsp_rdata=0; PSEL=0 on the following cycle.
